// File: rtl/oled_pkg.sv
// Shared state encoding and command tables for the 128x64 OLED frame sequencer.
package oled_pkg;

    typedef enum logic [2:0] {HOLD, WAIT, INIT, ADDR, STREAM} oled_state_e;

    localparam int INIT_LEN = 25;
    localparam int ADDR_LEN = 6;

    localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    // Horizontal addressing window covering the full panel: columns 0..127, pages 0..7.
    localparam logic [7:0] ADDR_CMDS [ADDR_LEN] = '{
        8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

endpackage

// File: rtl/oled_frame_sequencer_spi.sv
// SPI mode-0 byte transmitter: one load cycle, then 8 MSB-first bits of 2*CLK_DIV clocks each.
module spi_byte_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       sclk,
    output logic       mosi,
    output logic [2:0] bit_idx,
    output logic       bit_done,
    output logic       byte_done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [7:0]    shreg;
    logic          active;
    logic          half_end;

    assign half_end  = (div_cnt == DW'(CLK_DIV - 1));
    assign bit_done  = active && sclk && half_end;
    assign byte_done = bit_done && (bit_idx == 3'd7);
    assign mosi      = shreg[7];

    // Shifting on the falling sclk edge keeps mosi stable across the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            shreg   <= '0;
            active  <= 1'b0;
            sclk    <= 1'b0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= tx_byte;
            active  <= 1'b1;
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_idx <= '0;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (sclk) begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        active <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/oled_frame_sequencer.sv
// OLED power-up sequencing, init command stream and continuous frame refresh over 4-wire SPI.
module oled_frame_sequencer
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int RESET_HOLD = 10000,
    parameter int RESET_WAIT = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] row,
    output logic [6:0] col,
    output logic [2:0] place,
    input  logic [7:0] data,
    output logic       dc,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       res_n,
    output logic       streaming
);

    oled_state_e state_q, state_d;
    logic [31:0] cnt;
    logic [4:0]  rom_idx;
    logic        in_byte;
    logic        load;
    logic [7:0]  tx_byte;
    logic [2:0]  bit_idx;
    logic        bit_done, byte_done;

    spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .tx_byte   (tx_byte),
        .sclk      (sclk),
        .mosi      (mosi),
        .bit_idx   (bit_idx),
        .bit_done  (bit_done),
        .byte_done (byte_done)
    );

    // Next byte loads the cycle after the previous one finishes, so cs_n never gaps.
    assign load      = (state_q inside {INIT, ADDR, STREAM}) && !in_byte;
    assign res_n     = (state_q != HOLD);
    assign cs_n      = (state_q inside {HOLD, WAIT});
    assign dc        = (state_q == STREAM);
    assign streaming = (state_q == STREAM);
    assign place     = (state_q == STREAM) ? bit_idx : 3'd0;

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            INIT:    tx_byte = INIT_CMDS[rom_idx];
            ADDR:    tx_byte = ADDR_CMDS[rom_idx[2:0]];
            STREAM:  tx_byte = data;
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (cnt == 32'(RESET_HOLD - 1)) state_d = WAIT;
            WAIT:    if (cnt == 32'(RESET_WAIT - 1)) state_d = INIT;
            INIT:    if (byte_done && rom_idx == 5'(INIT_LEN - 1)) state_d = ADDR;
            ADDR:    if (byte_done && rom_idx == 5'(ADDR_LEN - 1)) state_d = STREAM;
            STREAM:  if (byte_done && row == 3'd7 && col == 7'd127) state_d = ADDR;
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt     <= '0;
            rom_idx <= '0;
            in_byte <= 1'b0;
            row     <= '0;
            col     <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt <= '0;
            else if (state_q inside {HOLD, WAIT})
                cnt <= cnt + 32'd1;

            if (state_d != state_q)
                rom_idx <= '0;
            else if (byte_done)
                rom_idx <= rom_idx + 5'd1;

            if (load)
                in_byte <= 1'b1;
            else if (byte_done)
                in_byte <= 1'b0;

            // Counters wrap naturally; the final frame bit rolls everything back to 0 for ADDR.
            if (state_q == STREAM && bit_done && bit_idx == 3'd7) begin
                col <= col + 7'd1;
                if (col == 7'd127)
                    row <= row + 3'd1;
            end
        end
    end

endmodule

// File: doc/oled_frame_sequencer.md
Name: oled_frame_sequencer

Overview:
Owns the 128x64 OLED display: SPI transmission, the power-up reset and init sequence, and continuous frame refresh.
It generates the row/col/place scan counters and the dc flag consumed by Game. It samples Game's pixel byte and shifts it out over 4-wire SPI (mode 0, MSB first).
Sits between Game and the top-level display pins.

Parameters:
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
RESET_HOLD, 10000, clk cycles res_n held low after reset
RESET_WAIT, 10000, clk cycles after res_n rises before first command

Ports:
clk  input  1  system clock
rst_n  input  1  reset
row  output  3  current page (0..7), to Game
col  output  7  current column (0..127), to Game
place  output  3  current bit within byte (0..7), to Game
data  input  8  pixel byte from Game for (row,col)
dc  output  1  0=command byte, 1=display data byte; also to Game
sclk  output  1  SPI clock, idle low
mosi  output  1  SPI data
cs_n  output  1  display chip select, active low
res_n  output  1  display hardware reset, active low
streaming  output  1  high while frame data is being sent

Behaviour:
- Reset rst_n, asynchronous, active-low; clock clk. In reset: state=HOLD, res_n=0, cs_n=1, sclk=0, mosi=0, dc=0, row/col/place=0, streaming=0.
- States: HOLD -> WAIT -> INIT -> ADDR -> STREAM -> ADDR ...
- HOLD: res_n=0 for RESET_HOLD cycles.
- WAIT: res_n=1, cs_n=1 for RESET_WAIT cycles.
- INIT: cs_n=0, dc=0. Sends the INIT_CMDS list in order (25 bytes), then enters ADDR. INIT is never re-entered without reset.
- ADDR: dc=0. Sends 0x21,0x00,0x7F,0x22,0x00,0x07, then enters STREAM. row/col/place are held at 0.
- STREAM: dc=1, streaming=1. Sends 1024 bytes: col 0..127 within row 0..7, col fastest. Then returns to ADDR.
- Byte timing: 1 LOAD cycle, then 8 bits of 2*CLK_DIV cycles each (sclk low half, then high half). A byte is therefore 16*CLK_DIV+1 cycles.
- Shift register loads in the LOAD cycle. In STREAM it loads from data; in command states it loads from the ROM/constant.
- mosi, dc and cs_n change only while sclk=0. The display samples mosi on the sclk rising edge.
- cs_n stays low continuously from INIT onward, with no gap between bytes.
- Scan counters update at the end of each bit, so they remain stable for the whole bit period:
  - place increments per bit.
  - After place=7, place wraps to 0 and col increments.
  - After col=127, col wraps to 0 and row increments.
- Before each LOAD cycle, row/col hold the byte's address with place=0 for >=1 clk, so Game's combinational data settles before sampling.
- row=7, col=127, place=7 occurs exactly once per frame, for the final bit (2*CLK_DIV cycles). It never occurs outside STREAM.
- dc transitions only in the LOAD cycle.
- Asynchronous reset mid-operation (any state) immediately forces the reset values and restarts at HOLD.

Decomposition:
- oled_pkg:
  - state enum {HOLD, WAIT, INIT, ADDR, STREAM}.
  - INIT_LEN=25.
  - INIT_CMDS: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
  - ADDR_CMDS: 21 00 7F 22 00 07.
- Sub-module spi_byte_tx: shift register plus sclk divider.
  - Inputs: load, byte.
  - Outputs: sclk, mosi, bit_idx, bit_done, byte_done.
  - The sequencer owns the FSM, the ROM index and the scan counters.

Test Plan:
- Reset timing (CLK_DIV=2, RESET_HOLD=8, RESET_WAIT=4): release reset -> res_n=0 for 8 clks, res_n=1 with cs_n=1 for 4 clks, then cs_n=0 and first byte 0xAE with dc=0.
- Init stream: decode mosi on sclk rising edges -> exactly 25 bytes equal to INIT_CMDS, each 33 clks apart, dc=0 throughout.
- Addr phase: bytes 0x21,0x00,0x7F,0x22,0x00,0x07 with dc=0 follow the last init byte (0xAF) with no extra gap; row/col/place=0.
- Frame data: data driven as {row,col[4:0]} -> 1024 decoded bytes match per (row,col), dc=1, place equals bit index during every bit.
- Frame marker: row=7, col=127, place=7 held exactly 4 clks per frame; the next byte is 0x21 with dc=0, and a second frame repeats identically.
- Async reset at row=3, col=50, mid-bit -> same cycle: res_n=0, cs_n=1, sclk=0, counters=0; the full HOLD/WAIT/INIT sequence repeats.
